// File: rtl/serial_adder.sv
// Multi-cycle LSB-first adder: DIGIT bits per clock through a registered-carry slice.
// Optional subtraction (sub port, ~b with inverted carry-in) is built when SERIAL_ADDER_SUB_EN is defined.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $error("serial_adder: DIGIT must be in 1..WIDTH and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, psum, psum_next, b_load;
  logic             carry, cin_load;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] a_d, b_d, d_sum;
  logic [DIGIT:0]   d_full;
  logic             d_cout, d_cmsb;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_load   = sub ? ~b : b;
  assign cin_load = sub ^ cin;
`else
  assign b_load   = b;
  assign cin_load = cin;
`endif

  assign a_d    = a_sh[DIGIT-1:0];
  assign b_d    = b_sh[DIGIT-1:0];
  assign d_full = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT{1'b0}}, carry};
  assign d_sum  = d_full[DIGIT-1:0];
  assign d_cout = d_full[DIGIT];
  // Carry into the slice's top bit, recovered from its sum bit; on the last digit this is the carry into the MSB.
  assign d_cmsb = d_sum[DIGIT-1] ^ a_d[DIGIT-1] ^ b_d[DIGIT-1];
  assign psum_next = (psum >> DIGIT) | (WIDTH'(d_sum) << (WIDTH - DIGIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b_load;
            carry <= cin_load;
            cnt   <= '0;
            state <= RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          carry <= d_cout;
          psum  <= psum_next;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= psum_next;
            cout  <= d_cout;
            ovf   <= d_cmsb ^ d_cout;
            state <= DONE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
